axil_cfg_sequencer: RTL and testbench
=====================================

// Module: axil_cfg_sequencer
// PURPOSE
//  AXI4-Lite master that programs the axistream register bank. On start it writes NUM_REGS
//  words from cfg_data to consecutive registers at BASE_ADDR, BASE_ADDR+4, and so on.
//  If VERIFY=1 it then reads every register back and compares it with the value written.
//  Reports busy/done/error to the local controller, replacing software bring-up of the slave.
// PARAMETERS
//  C_M_AXI_ADDR_WIDTH  32     AXI address width
//  C_M_AXI_DATA_WIDTH  32     AXI data width (only 32 supported)
//  NUM_REGS            4      registers to program (1..16)
//  BASE_ADDR           'h0    byte address of register 0; stride 4
//  VERIFY              1      1 = readback+compare phase, 0 = writes only
// PORTS
//  ACLK           in   1            clock; all logic on rising edge
//  ARESETN        in   1            reset, asynchronous, active-low
//  start          in   1            pulse; sampled only in IDLE
//  cfg_data       in   NUM_REGS*32  reg i = cfg_data[32*i+:32]; latched on accepted start
//  busy           out  1            high from cycle after start until DONE/ERR
//  done           out  1            level; sequence finished OK, cleared by next start
//  error          out  1            level; sequence aborted, cleared by next start
//  err_index      out  4            register index that failed (valid while error)
//  err_code       out  2            0 none, 1 BRESP!=OKAY, 2 RRESP!=OKAY, 3 data mismatch
//  M_AXI_AWADDR/AWPROT/AWVALID out, AWREADY in      write address channel, AWPROT=3'b000
//  M_AXI_WDATA/WSTRB/WVALID out, WREADY in          write data, WSTRB=4'hF
//  M_AXI_BRESP/BVALID in, BREADY out                write response
//  M_AXI_ARADDR/ARPROT/ARVALID out, ARREADY in      read address, ARPROT=3'b000
//  M_AXI_RDATA/RRESP/RVALID in, RREADY out          read data
// BEHAVIOUR
//  Reset: state=IDLE; all VALID/READY, busy, done, error = 0; err_index, err_code, addr = 0.
//  States: IDLE -> WR_REQ -> WR_RESP -> (next reg: WR_REQ | last: RD_REQ or DONE)
//          RD_REQ -> RD_DATA -> (next reg: RD_REQ | last: DONE); any failure -> ERR.
//  IDLE/DONE/ERR: start=1 latches cfg_data, idx=0, clears done/error/err_*, goes to WR_REQ.
//    start is ignored in every other state.
//  WR_REQ: AWVALID and WVALID both rise in the first cycle. Each drops on its own handshake
//    (VALID&READY at the edge) and is never withdrawn before it. Both done -> WR_RESP.
//    AW and W may complete in either order or in the same cycle.
//  WR_RESP: BREADY=1. On BVALID: OKAY -> advance; else ERR with err_code=1.
//  RD_REQ: ARVALID=1 until ARREADY -> RD_DATA.
//  RD_DATA: RREADY=1. On RVALID: RRESP!=OKAY -> code 2; RDATA!=latched word -> code 3;
//    otherwise advance.
//  Address = BASE_ADDR + 4*idx, held stable while VALID is high. idx wraps to 0 between phases.
//  Latency with an always-ready slave: 2 cycles per write, 2 per read. NUM_REGS=4, VERIFY=1
//    gives done 16 cycles after start is sampled.
//  Outstanding transactions: at most one; no new address until the prior response.
//  ERR stops at the first failure; no further AXI traffic; err_index = failing idx.
//  ARESETN low mid-transfer: all VALIDs drop asynchronously and the FSM returns to IDLE.
//    No resume; the sequence restarts only on a new start.
// STRUCTURE
//  Package axil_cfg_pkg: state enum (IDLE, WR_REQ, WR_RESP, RD_REQ, RD_DATA, DONE, ERR).
//    Also holds RESP_OKAY=2'b00 and the err_code localparams.
//  Single module, no sub-module: FSM, idx counter, aw_done/w_done flags, cfg shadow register.
// TESTING
//  1 Always-ready slave, cfg 1,2,3,4 -> writes to 0x0,0x4,0x8,0xC; reads match; done at +16.
//  2 AWREADY delayed 3 cycles, WREADY immediate -> WVALID drops first; AWADDR stable; done=1.
//  3 Slave returns BRESP=SLVERR on reg 2 -> error=1, err_code=1, err_index=2, no AR issued.
//  4 Slave corrupts RDATA of reg 3 (0x4->0x5) -> err_code=3, err_index=3, done=0.
//  5 ARESETN low during WR_RESP of reg 1 -> VALIDs 0 immediately; restart completes OK.
//  6 start asserted while busy -> ignored, sequence unchanged; VERIFY=0 -> done at +8, no AR.

Source files
------------

// File: rtl/axil_cfg_sequencer_pkg.sv
// Shared types and constants for the AXI4-Lite configuration sequencer.
package axil_cfg_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_REQ  = 3'd1,
        WR_RESP = 3'd2,
        RD_REQ  = 3'd3,
        RD_DATA = 3'd4,
        DONE    = 3'd5,
        ERR     = 3'd6
    } state_t;

    localparam logic [1:0] RESP_OKAY = 2'b00;

    localparam logic [1:0] ERR_NONE  = 2'd0;
    localparam logic [1:0] ERR_BRESP = 2'd1;
    localparam logic [1:0] ERR_RRESP = 2'd2;
    localparam logic [1:0] ERR_DATA  = 2'd3;

endpackage

// File: rtl/axil_cfg_sequencer_if.sv
// AXI4-Lite bus bundle; every channel uses VALID/READY and a beat transfers on the
// rising edge where both are high. VALID is never withdrawn before its handshake.
interface axil_cfg_sequencer_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic [AW-1:0]   awaddr;
    logic [2:0]      awprot;
    logic            awvalid;
    logic            awready;
    logic [DW-1:0]   wdata;
    logic [DW/8-1:0] wstrb;
    logic            wvalid;
    logic            wready;
    logic [1:0]      bresp;
    logic            bvalid;
    logic            bready;
    logic [AW-1:0]   araddr;
    logic [2:0]      arprot;
    logic            arvalid;
    logic            arready;
    logic [DW-1:0]   rdata;
    logic [1:0]      rresp;
    logic            rvalid;
    logic            rready;

    modport master (
        output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
               araddr, arprot, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
               araddr, arprot, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/axil_cfg_sequencer.sv
// AXI4-Lite master that writes NUM_REGS words to consecutive registers and optionally
// reads them back to confirm, reporting busy/done/error to the local controller.
module axil_cfg_sequencer
    import axil_cfg_pkg::*;
#(
    parameter int C_M_AXI_ADDR_WIDTH = 32,
    parameter int C_M_AXI_DATA_WIDTH = 32,
    parameter int NUM_REGS           = 4,
    parameter logic [C_M_AXI_ADDR_WIDTH-1:0] BASE_ADDR = '0,
    parameter bit VERIFY             = 1'b1
) (
    input  logic                  ACLK,
    input  logic                  ARESETN,
    input  logic                  start,
    input  logic [NUM_REGS*32-1:0] cfg_data,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [3:0]            err_index,
    output logic [1:0]            err_code,
    output state_t                dbg_state,
    axil_cfg_sequencer_if.master  m_axi
);

    localparam logic [3:0] LAST_IDX = 4'(NUM_REGS - 1);

    state_t                 state_q, state_d;
    logic [3:0]             idx_q, idx_d;
    logic                   aw_done_q, aw_done_d;
    logic                   w_done_q, w_done_d;
    logic [NUM_REGS*32-1:0] cfg_q, cfg_d;
    logic [3:0]             err_index_q, err_index_d;
    logic [1:0]             err_code_q, err_code_d;

    logic [C_M_AXI_ADDR_WIDTH-1:0] addr;
    logic [31:0]            cur_word;
    logic                   awvalid, wvalid, arvalid;
    logic                   aw_now, w_now, last;

    assign addr     = BASE_ADDR + {{(C_M_AXI_ADDR_WIDTH-6){1'b0}}, idx_q, 2'b00};
    assign cur_word = cfg_q[32*idx_q +: 32];
    assign last     = (idx_q == LAST_IDX);
    assign aw_now   = aw_done_q | (awvalid & m_axi.awready);
    assign w_now    = w_done_q  | (wvalid  & m_axi.wready);

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            aw_done_q   <= 1'b0;
            w_done_q    <= 1'b0;
            cfg_q       <= '0;
            err_index_q <= '0;
            err_code_q  <= ERR_NONE;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            aw_done_q   <= aw_done_d;
            w_done_q    <= w_done_d;
            cfg_q       <= cfg_d;
            err_index_q <= err_index_d;
            err_code_q  <= err_code_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        aw_done_d   = aw_done_q;
        w_done_d    = w_done_q;
        cfg_d       = cfg_q;
        err_index_d = err_index_q;
        err_code_d  = err_code_q;
        case (state_q)
            IDLE, DONE, ERR: begin
                if (start) begin
                    cfg_d       = cfg_data;
                    idx_d       = '0;
                    aw_done_d   = 1'b0;
                    w_done_d    = 1'b0;
                    err_index_d = '0;
                    err_code_d  = ERR_NONE;
                    state_d     = WR_REQ;
                end
            end
            WR_REQ: begin
                // AW and W complete independently; leave only once both have handshaken.
                if (aw_now && w_now) begin
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    state_d   = WR_RESP;
                end else begin
                    aw_done_d = aw_now;
                    w_done_d  = w_now;
                end
            end
            WR_RESP: begin
                if (m_axi.bvalid) begin
                    if (m_axi.bresp != RESP_OKAY) begin
                        err_index_d = idx_q;
                        err_code_d  = ERR_BRESP;
                        state_d     = ERR;
                    end else if (last) begin
                        idx_d   = '0;
                        state_d = VERIFY ? RD_REQ : DONE;
                    end else begin
                        idx_d   = idx_q + 4'd1;
                        state_d = WR_REQ;
                    end
                end
            end
            RD_REQ: begin
                if (m_axi.arready) state_d = RD_DATA;
            end
            RD_DATA: begin
                if (m_axi.rvalid) begin
                    if (m_axi.rresp != RESP_OKAY) begin
                        err_index_d = idx_q;
                        err_code_d  = ERR_RRESP;
                        state_d     = ERR;
                    end else if (m_axi.rdata != cur_word) begin
                        err_index_d = idx_q;
                        err_code_d  = ERR_DATA;
                        state_d     = ERR;
                    end else if (last) begin
                        idx_d   = '0;
                        state_d = DONE;
                    end else begin
                        idx_d   = idx_q + 4'd1;
                        state_d = RD_REQ;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs decode the registered state only, so reset clears every VALID at once.
    always_comb begin
        awvalid = (state_q == WR_REQ) && !aw_done_q;
        wvalid  = (state_q == WR_REQ) && !w_done_q;
        arvalid = (state_q == RD_REQ);
        busy    = (state_q == WR_REQ) || (state_q == WR_RESP) ||
                  (state_q == RD_REQ) || (state_q == RD_DATA);
        done    = (state_q == DONE);
        error   = (state_q == ERR);
    end

    assign m_axi.awaddr  = addr;
    assign m_axi.awprot  = 3'b000;
    assign m_axi.awvalid = awvalid;
    assign m_axi.wdata   = cur_word;
    assign m_axi.wstrb   = 4'hF;
    assign m_axi.wvalid  = wvalid;
    assign m_axi.bready  = (state_q == WR_RESP);
    assign m_axi.araddr  = addr;
    assign m_axi.arprot  = 3'b000;
    assign m_axi.arvalid = arvalid;
    assign m_axi.rready  = (state_q == RD_DATA);

    assign err_index = err_index_q;
    assign err_code  = err_code_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_axil_cfg_sequencer.sv
// Directed bench for the configuration sequencer: a reactive AXI4-Lite slave per DUT
// and a linear list of steps checked with immediate assertions.
module tb_axil_cfg_sequencer;
    import axil_cfg_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // DUT 1: VERIFY=1
    axil_cfg_sequencer_if #(.AW(32), .DW(32)) bus ();
    logic         start = 1'b0;
    logic [127:0] cfg_data = '0;
    logic         busy, done, error;
    logic [3:0]   err_index;
    logic [1:0]   err_code;
    state_t       dbg_state;

    axil_cfg_sequencer #(.NUM_REGS(4), .BASE_ADDR(32'h0), .VERIFY(1'b1)) dut (
        .ACLK(clk), .ARESETN(rst_n), .start(start), .cfg_data(cfg_data),
        .busy(busy), .done(done), .error(error), .err_index(err_index),
        .err_code(err_code), .dbg_state(dbg_state), .m_axi(bus)
    );

    // DUT 2: VERIFY=0
    axil_cfg_sequencer_if #(.AW(32), .DW(32)) bus2 ();
    logic         start2 = 1'b0;
    logic [127:0] cfg_data2 = '0;
    logic         busy2, done2, error2;
    logic [3:0]   err_index2;
    logic [1:0]   err_code2;
    state_t       dbg_state2;

    axil_cfg_sequencer #(.NUM_REGS(4), .BASE_ADDR(32'h0), .VERIFY(1'b0)) dut2 (
        .ACLK(clk), .ARESETN(rst_n), .start(start2), .cfg_data(cfg_data2),
        .busy(busy2), .done(done2), .error(error2), .err_index(err_index2),
        .err_code(err_code2), .dbg_state(dbg_state2), .m_axi(bus2)
    );

    // Slave 1 knobs and observations
    int          aw_delay = 0;
    int          berr_idx = -1;
    int          rbad_idx = -1;
    int          ar_cnt = 0;
    logic [31:0] mem [0:15];
    logic [31:0] aw_log[$];
    logic [31:0] exp_q[$];

    initial begin
        logic aw_hs, w_hs, b_hs, ar_hs, r_hs, aw_got, w_got;
        logic [31:0] awaddr_s, wdata_s, araddr_s, aw_a, w_d;
        int cnt;
        aw_got = 0; w_got = 0; cnt = 0; aw_a = '0; w_d = '0;
        for (int i = 0; i < 16; i++) mem[i] = '0;
        bus.awready = 0; bus.wready = 0; bus.bvalid = 0; bus.bresp = 2'b00;
        bus.arready = 0; bus.rvalid = 0; bus.rdata = '0; bus.rresp = 2'b00;
        forever begin
            @(posedge clk);
            aw_hs = bus.awvalid && bus.awready;
            w_hs  = bus.wvalid && bus.wready;
            b_hs  = bus.bvalid && bus.bready;
            ar_hs = bus.arvalid && bus.arready;
            r_hs  = bus.rvalid && bus.rready;
            if (bus.arvalid) ar_cnt++;
            awaddr_s = bus.awaddr; wdata_s = bus.wdata; araddr_s = bus.araddr;
            #1;
            if (!rst_n) begin
                aw_got = 0; w_got = 0; cnt = 0;
                bus.awready = 0; bus.wready = 0; bus.bvalid = 0;
                bus.arready = 0; bus.rvalid = 0;
                continue;
            end
            if (aw_hs) begin aw_got = 1; aw_a = awaddr_s; aw_log.push_back(awaddr_s); end
            if (w_hs) begin w_got = 1; w_d = wdata_s; end
            if (b_hs) bus.bvalid = 0;
            if (aw_got && w_got) begin
                mem[aw_a[5:2]] = w_d;
                bus.bresp  = (int'(aw_a[5:2]) == berr_idx) ? 2'b10 : 2'b00;
                bus.bvalid = 1;
                aw_got = 0; w_got = 0;
            end
            if (r_hs) bus.rvalid = 0;
            if (ar_hs) begin
                bus.rdata  = mem[araddr_s[5:2]];
                if (int'(araddr_s[5:2]) == rbad_idx) bus.rdata = bus.rdata ^ 32'h1;
                bus.rresp  = 2'b00;
                bus.rvalid = 1;
            end
            bus.wready  = 1;
            bus.arready = 1;
            if (aw_delay == 0) begin
                bus.awready = 1;
            end else if (bus.awvalid) begin
                bus.awready = (cnt >= aw_delay);
                cnt++;
            end else begin
                bus.awready = 0;
                cnt = 0;
            end
        end
    end

    // Slave 2: always ready, no faults
    int          ar_cnt2 = 0;
    logic [31:0] mem2 [0:15];

    initial begin
        logic aw_hs, w_hs, b_hs, ar_hs, r_hs, aw_got, w_got;
        logic [31:0] awaddr_s, wdata_s, araddr_s, aw_a, w_d;
        aw_got = 0; w_got = 0; aw_a = '0; w_d = '0;
        for (int i = 0; i < 16; i++) mem2[i] = '0;
        bus2.awready = 1; bus2.wready = 1; bus2.bvalid = 0; bus2.bresp = 2'b00;
        bus2.arready = 1; bus2.rvalid = 0; bus2.rdata = '0; bus2.rresp = 2'b00;
        forever begin
            @(posedge clk);
            aw_hs = bus2.awvalid && bus2.awready;
            w_hs  = bus2.wvalid && bus2.wready;
            b_hs  = bus2.bvalid && bus2.bready;
            ar_hs = bus2.arvalid && bus2.arready;
            r_hs  = bus2.rvalid && bus2.rready;
            if (bus2.arvalid) ar_cnt2++;
            awaddr_s = bus2.awaddr; wdata_s = bus2.wdata; araddr_s = bus2.araddr;
            #1;
            if (!rst_n) begin
                aw_got = 0; w_got = 0; bus2.bvalid = 0; bus2.rvalid = 0;
                continue;
            end
            if (aw_hs) begin aw_got = 1; aw_a = awaddr_s; end
            if (w_hs) begin w_got = 1; w_d = wdata_s; end
            if (b_hs) bus2.bvalid = 0;
            if (aw_got && w_got) begin
                mem2[aw_a[5:2]] = w_d;
                bus2.bvalid = 1;
                aw_got = 0; w_got = 0;
            end
            if (r_hs) bus2.rvalid = 0;
            if (ar_hs) begin
                bus2.rdata = mem2[araddr_s[5:2]];
                bus2.rvalid = 1;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic do_start(input logic [127:0] d);
        cfg_data = d;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_end(input string tag, input int budget);
        int cyc;
        cyc = 0;
        while (!(done || error) && cyc < budget) begin
            tick();
            cyc++;
        end
        check(tag, 32'(done | error), 32'd1);
    endtask

    localparam logic [127:0] CFG_A = {32'd4, 32'd3, 32'd2, 32'd1};
    localparam logic [127:0] CFG_B = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
    localparam logic [127:0] CFG_C = {32'h44, 32'h33, 32'h22, 32'h11};
    localparam logic [127:0] CFG_D = {32'hDEAD0003, 32'hDEAD0002, 32'hDEAD0001, 32'hDEAD0000};

    initial begin
        logic [31:0] e;
        // Reset state
        #12;
        check("rst_state", 32'(dbg_state), 32'(IDLE));
        check("rst_flags", {29'd0, busy, done, error}, 32'd0);
        check("rst_valids", {27'd0, bus.awvalid, bus.wvalid, bus.bready, bus.arvalid, bus.rready}, 32'd0);
        check("rst_err", {26'd0, err_index, err_code}, 32'd0);
        check("rst_addr", bus.awaddr, 32'd0);
        tick(); tick();
        rst_n = 1'b1;
        tick(); tick();

        // 1: always-ready slave, done exactly 16 cycles after start
        aw_log.delete();
        ar_cnt = 0;
        do_start(CFG_A);
        check("t1_busy", 32'(busy), 32'd1);
        check("t1_aw_w_valid", {30'd0, bus.awvalid, bus.wvalid}, 32'd3);
        for (int i = 0; i < 15; i++) tick();
        check("t1_done_pre16", 32'(done), 32'd0);
        tick();
        check("t1_done_at16", 32'(done), 32'd1);
        check("t1_busy_end", {30'd0, busy, error}, 32'd0);
        exp_q = '{32'h0, 32'h4, 32'h8, 32'hC};
        check("t1_aw_count", 32'(aw_log.size()), 32'd4);
        while (exp_q.size() > 0 && aw_log.size() > 0) begin
            e = exp_q.pop_front();
            check("t1_awaddr", aw_log.pop_front(), e);
        end
        check("t1_mem0", mem[0], 32'd1);
        check("t1_mem3", mem[3], 32'd4);
        check("t1_ar_count", 32'(ar_cnt), 32'd4);

        // 2: AWREADY held off 3 cycles, W completes first
        aw_delay = 3;
        tick();
        do_start(CFG_B);
        check("t2_both_valid", {30'd0, bus.awvalid, bus.wvalid}, 32'd3);
        tick();
        check("t2_w_dropped", {30'd0, bus.awvalid, bus.wvalid}, 32'd2);
        check("t2_addr_c1", bus.awaddr, 32'h0);
        tick(); tick();
        check("t2_aw_still", 32'(bus.awvalid), 32'd1);
        check("t2_addr_c3", bus.awaddr, 32'h0);
        tick();
        check("t2_wr_resp", 32'(dbg_state), 32'(WR_RESP));
        wait_end("t2_timeout", 100);
        check("t2_done", {30'd0, done, error}, 32'd2);
        check("t2_mem2", mem[2], 32'hA2);
        aw_delay = 0;
        tick();

        // 3: BRESP=SLVERR on reg 2
        berr_idx = 2;
        ar_cnt = 0;
        aw_log.delete();
        do_start(CFG_A);
        check("t3_done_cleared", 32'(done), 32'd0);
        wait_end("t3_timeout", 50);
        check("t3_error", {30'd0, done, error}, 32'd1);
        check("t3_err_code", 32'(err_code), 32'd1);
        check("t3_err_index", 32'(err_index), 32'd2);
        for (int i = 0; i < 5; i++) tick();
        check("t3_no_ar", 32'(ar_cnt), 32'd0);
        check("t3_no_more_aw", 32'(aw_log.size()), 32'd3);
        check("t3_idle_bus", {29'd0, bus.awvalid, bus.wvalid, busy}, 32'd0);
        berr_idx = -1;

        // 4: corrupted read data on reg 3
        rbad_idx = 3;
        do_start(CFG_A);
        check("t4_error_cleared", {30'd0, error, err_code == 2'd0}, 32'd1);
        wait_end("t4_timeout", 50);
        check("t4_err_code", 32'(err_code), 32'd3);
        check("t4_err_index", 32'(err_index), 32'd3);
        check("t4_flags", {30'd0, done, error}, 32'd1);
        rbad_idx = -1;

        // 5: reset during WR_RESP of reg 1, then a clean restart
        do_start(CFG_A);
        tick(); tick(); tick();
        check("t5_in_wr_resp1", 32'(dbg_state), 32'(WR_RESP));
        check("t5_bready", 32'(bus.bready), 32'd1);
        rst_n = 1'b0;
        #1;
        check("t5_async_idle", 32'(dbg_state), 32'(IDLE));
        check("t5_async_bus", {27'd0, bus.awvalid, bus.wvalid, bus.bready, bus.arvalid, busy}, 32'd0);
        tick(); tick();
        rst_n = 1'b1;
        tick();
        check("t5_stays_idle", 32'(dbg_state), 32'(IDLE));
        do_start(CFG_C);
        wait_end("t5_timeout", 50);
        check("t5_done", {30'd0, done, error}, 32'd2);
        check("t5_mem1", mem[1], 32'h22);

        // 6: start while busy is ignored
        do_start(CFG_D);
        tick(); tick(); tick();
        cfg_data = CFG_A;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("t6_still_busy", 32'(busy), 32'd1);
        for (int i = 0; i < 11; i++) tick();
        check("t6_done_pre16", 32'(done), 32'd0);
        tick();
        check("t6_done_at16", {30'd0, done, error}, 32'd2);
        check("t6_mem0", mem[0], 32'hDEAD0000);
        check("t6_mem3", mem[3], 32'hDEAD0003);

        // 6b: VERIFY=0 finishes after writes only
        ar_cnt2 = 0;
        cfg_data2 = CFG_B;
        start2 = 1'b1;
        tick();
        start2 = 1'b0;
        for (int i = 0; i < 7; i++) tick();
        check("t6b_done_pre8", 32'(done2), 32'd0);
        tick();
        check("t6b_done_at8", {30'd0, done2, error2}, 32'd2);
        check("t6b_no_ar", 32'(ar_cnt2), 32'd0);
        check("t6b_mem3", mem2[3], 32'hA3);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
